// File: rtl/k12a_alu_ctrl.sv
// k12a ALU control: accepts decoded ALU / compare-skip instructions, sequences the
// ALU control lines, and owns accumulator A plus the skip flag for fetch.
module k12a_alu_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [7:0]  data_bus,
  input  logic        alu_condition,
  output logic [15:0] alu_inst,
  output logic        alu_operand_sel,
  output logic        alu_subtract,
  output logic        alu_load,
  output logic [7:0]  a_out,
  output logic        skip,
  output logic        done,
  output logic        illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] EVAL = 2'd3;

  localparam logic ALU_OPERAND_SEL_B    = 1'b0;
  localparam logic ALU_OPERAND_SEL_INST = 1'b1;

  localparam logic [2:0] ALU_OP_SUB = 3'h5;

  logic [1:0]  state_q, state_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  a_q, a_d;
  logic        skip_q, skip_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic        inst_legal;
  logic        busy;
  logic        op_is_skip;

  // Legal opcodes are 4..7, i.e. inst[15:14] == 2'b01.
  assign inst_legal = (inst[15:14] == 2'b01);
  assign inst_ready = (state_q == IDLE);
  assign accept     = inst_valid && inst_ready;
  assign busy       = (state_q != IDLE);
  assign op_is_skip = inst_q[13];

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    a_d       = a_q;
    skip_d    = skip_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          inst_d = inst;
          if (inst_legal) begin
            state_d = EXEC;
          end else begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        state_d = op_is_skip ? EVAL : WB;
      end
      WB: begin
        a_d     = data_bus;
        skip_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      EVAL: begin
        skip_d  = alu_condition ^ inst_q[11];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      inst_q    <= 16'h0000;
      a_q       <= 8'h00;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      a_q       <= a_d;
      skip_q    <= skip_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // ALU control is decoded from state_q so an async reset releases the bus at once.
  always_comb begin
    alu_inst        = inst_q;
    alu_operand_sel = ALU_OPERAND_SEL_B;
    alu_subtract    = 1'b0;
    if (busy) begin
      alu_operand_sel = inst_q[12] ? ALU_OPERAND_SEL_INST : ALU_OPERAND_SEL_B;
      alu_subtract    = op_is_skip || (inst_q[10:8] == ALU_OP_SUB);
    end
  end

  assign alu_load = (state_q == WB);
  assign a_out    = a_q;
  assign skip     = skip_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: doc/k12a_alu_ctrl.md
Name: k12a_alu_ctrl

Overview:
Control-side counterpart to the k12a ALU datapath. Accepts decoded ALU and compare-skip instructions over a valid/ready handshake, then drives the ALU's control inputs (alu_load, alu_operand_sel, alu_subtract, inst). It owns accumulator register A, which feeds the ALU's a input. It captures the ALU result from data_bus into A, or samples alu_condition to produce a skip flag for the fetch unit.

Parameters:
None (8-bit datapath, 16-bit instruction word, fixed by the k12a ISA).

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
inst  input  16  instruction word offered by decode
inst_valid  input  1  inst is valid this cycle
inst_ready  output  1  block can accept inst this cycle
data_bus  input  8  shared bus, sampled only while alu_load=1
alu_condition  input  1  selected ALU flag
alu_inst  output  16  latched instruction to ALU inst input
alu_operand_sel  output  alu_operand_sel_t  ALU_OPERAND_SEL_B or ALU_OPERAND_SEL_INST
alu_subtract  output  1  ALU adder subtract/compare mode
alu_load  output  1  ALU drives data_bus
a_out  output  8  accumulator A, to ALU a input
skip  output  1  result of last compare-skip instruction
done  output  1  one-cycle completion pulse
illegal  output  1  one-cycle pulse with done for an unrecognised opcode

Behaviour:
- Reset (async, reset_n=0): state=IDLE, inst_q=0, a_out=0, skip=0, done=0, illegal=0. alu_load=0 immediately, including mid-operation. This prevents bus contention.
- Opcode field is inst[15:12]:
  - 4'h4: ALU op, operand B.
  - 4'h5: ALU op, immediate inst[7:0].
  - 4'h6: compare-skip, operand B.
  - 4'h7: compare-skip, immediate.
  - Any other value is illegal.
- inst[10:8] selects the ALU op/condition. inst[11] inverts the condition for skip ops only.
- States: IDLE, EXEC, WB, EVAL.
- IDLE:
  - inst_ready=1.
  - On inst_valid at a clock edge: inst_q<=inst.
  - Next state: EXEC if the opcode is legal. If illegal, stay IDLE and pulse done=1 and illegal=1 next cycle; a_out and skip are unchanged.
- EXEC:
  - inst_ready=0; alu_load=0.
  - Next state: WB for opcodes 4/5, EVAL for opcodes 6/7.
- WB:
  - alu_load=1.
  - At the edge: a_out<=data_bus, skip<=0, state<=IDLE, done<=1 for one cycle.
- EVAL:
  - alu_load=0.
  - At the edge: skip<=alu_condition^inst_q[11], state<=IDLE, done<=1 for one cycle.
- Control outputs (combinational from state and inst_q):
  - In EXEC/WB/EVAL: alu_inst=inst_q; alu_operand_sel=INST when inst_q[12]=1, else B.
  - alu_subtract=1 when opcode is 6/7, or opcode is 4/5 with inst_q[10:8]=3'h5; otherwise 0.
  - In IDLE: alu_inst holds inst_q; alu_operand_sel=B; alu_subtract=0.
- Timing and hazards:
  - Latency: accept edge E0, result visible and done=1 in the cycle after E0+2 edges.
  - Throughput: one instruction per 3 cycles. Back-to-back accept is allowed in the done cycle, since the state is IDLE.
  - alu_load is never 1 outside WB.
- Persistence:
  - skip holds its value until the next legal instruction completes.
  - a_out changes only at a WB edge.
  - inst_valid while not ready is ignored; the source must hold it.

Test Plan:
- Bench with the real ALU wired (a=a_out, b=8'h10). Hold reset_n=0 → a_out=0, skip=0, alu_load=0, inst_ready=1. Deassert reset_n, offer 16'h5735 → WB has alu_load=1, operand_sel=INST; done pulses; a_out=8'h35.
- 16'h5402 (add imm) after A=35 → a_out=8'h37, alu_subtract=0 throughout. Then 16'h4500 (sub B) → a_out=8'h27, alu_subtract=1 in EXEC and WB.
- A=8'h37: 16'h7437 (ult imm) → skip=0, a_out unchanged. 16'h7C37 → skip=1. 16'h6400 (37<10 unsigned) → skip=0.
- Illegal 16'hF000 → done=1 and illegal=1 one cycle after accept; a_out and skip unchanged; alu_load never asserted.
- Assert reset_n=0 during a WB cycle of 16'h5799 → alu_load drops the same cycle, state=IDLE, a_out=0. After release, the next instruction executes normally.
- Hold inst_valid through 3 back-to-back instructions → each accepted exactly once, in the done cycle of its predecessor (3-cycle spacing); no accept during EXEC/WB/EVAL.
